// File: rtl/traffic_light_pkg.sv
// Purpose: shared traffic-light types, default phase durations and a binary-to-BCD helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: tl_state_t (GREEN/YELLOW/RED encodings shared with traffic_light_fsm),
//           DEF_* durations and sizes, bcd_t digit pair, bin_to_bcd().
package traffic_light_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10
   } tl_state_t;

   localparam int DEF_TICK_DIV    = 10_000_000;  // 10 MHz clock -> 1 s tick
   localparam int DEF_GREEN_TIME  = 15;
   localparam int DEF_YELLOW_TIME = 3;
   localparam int DEF_RED_TIME    = 10;
   localparam int DEF_CNT_W       = 7;           // holds 0..99 seconds

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   // Two-digit split; only meaningful for 0..99, which every legal duration respects.
   function automatic bcd_t bin_to_bcd(input int unsigned v);
      bcd_t r;
      r.tens = 4'(v / 10);
      r.ones = 4'(v % 10);
      return r;
   endfunction

endpackage

// File: rtl/traffic_light_timer_if.sv
// Purpose: timer interface between the traffic-light FSM (master) and the countdown timer (slave).
// Latency: n/a (wires only).
// Backpressure: none; load is a single-cycle request, timer_zero a single-cycle reply.
// Signals: timer_load, state_in, enable (FSM -> timer);
//          timer_zero, remaining, bcd_tens, bcd_ones, tick, load_err (timer -> FSM/display).
interface traffic_light_timer_if #(
   parameter int CNT_W = 7
);
   logic             timer_load;
   logic [1:0]       state_in;
   logic             enable;
   logic             timer_zero;
   logic [CNT_W-1:0] remaining;
   logic [3:0]       bcd_tens;
   logic [3:0]       bcd_ones;
   logic             tick;
   logic             load_err;

   modport master (
      output timer_load, state_in, enable,
      input  timer_zero, remaining, bcd_tens, bcd_ones, tick, load_err
   );

   modport slave (
      input  timer_load, state_in, enable,
      output timer_zero, remaining, bcd_tens, bcd_ones, tick, load_err
   );
endinterface

// File: rtl/tl_prescaler.sv
// Purpose: free-running 0..TICK_DIV-1 counter producing a one-cycle tick strobe.
// Latency: tick is combinational from the count; the count wraps on the tick edge.
// Backpressure: enable = 0 freezes the count (no tick lost or added); clr restarts it.
// Ports: clk, rst (sync, active-high), clr (sync restart), enable, tick.
module tl_prescaler #(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic enable,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // clr beats enable so a reload always starts a full second, even while paused.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/traffic_light_timer.sv
// Purpose: phase countdown timer for the traffic-light FSM, with binary and BCD seconds display.
// Latency: remaining/BCD update one edge after load; timer_zero follows D*TICK_DIV edges after load.
// Backpressure: none; enable = 0 pauses the countdown, a load always takes effect.
// Ports: clk, rst (sync, active-high), bus (traffic_light_timer_if.slave):
//        in  timer_load, state_in, enable; out timer_zero, remaining, bcd_tens, bcd_ones, tick, load_err.
module traffic_light_timer
   import traffic_light_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int GREEN_TIME  = DEF_GREEN_TIME,
   parameter int YELLOW_TIME = DEF_YELLOW_TIME,
   parameter int RED_TIME    = DEF_RED_TIME,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   traffic_light_timer_if.slave bus
);

   logic             tick;
   logic [CNT_W-1:0] dur;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_nxt;
   logic             zero_q;
   logic             zero_nxt;
   logic             err_q;
   logic             err_nxt;
   bcd_t             bcd_q;
   bcd_t             bcd_nxt;

   tl_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.timer_load),
      .enable (bus.enable),
      .tick   (tick)
   );

   // Unknown state code falls back to the longest-safe phase (RED).
   always_comb begin
      dur = CNT_W'(RED_TIME);
      case (bus.state_in)
         GREEN:   dur = CNT_W'(GREEN_TIME);
         YELLOW:  dur = CNT_W'(YELLOW_TIME);
         default: dur = CNT_W'(RED_TIME);
      endcase
   end

   // Load wins over a coincident tick, which also suppresses the expiry pulse on that edge.
   always_comb begin
      rem_nxt  = rem_q;
      zero_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (bus.timer_load) begin
         rem_nxt = dur;
         err_nxt = (bus.state_in == 2'b11);
      end else if (tick && (rem_q != '0)) begin
         rem_nxt  = rem_q - CNT_W'(1);
         zero_nxt = (rem_q == CNT_W'(1));
      end
   end

   // BCD is taken from the next count so digits and binary change on the same edge.
   assign bcd_nxt = bin_to_bcd(32'(rem_nxt));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
         bcd_q  <= '0;
      end else begin
         rem_q  <= rem_nxt;
         zero_q <= zero_nxt;
         err_q  <= err_nxt;
         bcd_q  <= bcd_nxt;
      end
   end

   assign bus.remaining  = rem_q;
   assign bus.timer_zero = zero_q;
   assign bus.load_err   = err_q;
   assign bus.bcd_tens   = bcd_q.tens;
   assign bus.bcd_ones   = bcd_q.ones;
   assign bus.tick       = tick;

endmodule

// File: doc/traffic_light_timer.md
Name: traffic_light_timer

Overview:
- Countdown timer on the far side of the traffic-light FSM's timer interface.
- Consumes the FSM's `timer_load` pulse and `current_state`, loads the phase duration in seconds, and counts down on an internal 1 Hz tick.
- Returns a one-cycle `timer_zero` pulse to the FSM at expiry.
- Also exports the remaining seconds, in binary and BCD, for the countdown display.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per 1 s tick (10 MHz system clock); bench uses 4.
- GREEN_TIME, 15, GREEN phase duration in seconds.
- YELLOW_TIME, 3, YELLOW phase duration in seconds.
- RED_TIME, 10, RED phase duration in seconds.
- CNT_W, 7, remaining-seconds width; all durations must lie in 1..99.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  reset.
- timer_load  in  1  load request from FSM; sampled every edge.
- state_in  in  2  FSM current_state: 00 GREEN, 01 YELLOW, 10 RED, 11 illegal.
- enable  in  1  1 = run; 0 = freeze prescaler and count (pause).
- timer_zero  out  1  one-cycle expiry pulse to FSM (registered).
- remaining  out  CNT_W  current seconds left (registered).
- bcd_tens  out  4  tens digit of remaining.
- bcd_ones  out  4  ones digit of remaining.
- tick  out  1  1 s tick strobe, one cycle wide (for display blink).
- load_err  out  1  one-cycle pulse when a load sees state_in = 11.

Interface: one clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.

Behaviour:
- **Reset** (rst high at an edge): prescaler = 0, remaining = 0, timer_zero = 0, tick = 0, load_err = 0, bcd_tens = 0, bcd_ones = 0.
  - Reset overrides every other input.
  - Reset mid-countdown aborts it; no timer_zero is issued.
- **Idle at 0:** with remaining = 0 the timer never pulses timer_zero on its own; it waits for a load. The FSM issues the first load after reset.
- **Prescaler:** counts 0..TICK_DIV-1 while enable = 1.
  - tick = 1 combinationally while prescaler == TICK_DIV-1 and enable = 1.
  - It wraps to 0 on that edge.
- **Load** (timer_load = 1 at an edge):
  - remaining <= duration(state_in); prescaler <= 0.
  - Duration map: 00 → GREEN_TIME, 01 → YELLOW_TIME, 10 → RED_TIME.
  - state_in = 11 → RED_TIME (fail-safe) and load_err pulses at that same edge.
  - Load has priority over a coincident tick (the tick is discarded) and over enable = 0.
- **Decrement:** at an edge with tick = 1, no load, and remaining > 0: remaining <= remaining - 1.
  - If remaining was 1, timer_zero <= 1 at that edge.
  - timer_zero is 0 at every other edge.
  - remaining then holds 0 with no wrap-around.
- **Latency:** load at edge E0, first decrement at E0 + TICK_DIV, timer_zero high in the cycle after edge E0 + D·TICK_DIV (D = duration).
- **Coincident load and expiry:** if timer_load arrives at the expiry edge, the load wins and timer_zero is not asserted.
- **Pause:** enable = 0 holds prescaler and remaining; a pause never causes a lost or extra tick.
- **BCD outputs:** bcd_tens/bcd_ones are registered from the next value of remaining, so they update at the same edge as remaining.
  - Conversion: tens = remaining / 10, ones = remaining % 10, valid for 0..99.

Decomposition:
- **Shared package** traffic_light_pkg:
  - State encodings GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, shared with traffic_light_fsm.
  - Default phase durations.
- **Sub-module** tl_prescaler:
  - Contents: parameterised TICK_DIV counter with enable and sync clear.
  - Outputs: tick.
  - Reused by any later 1 Hz logic.
- **Top-level logic:** duration mux, down-counter, expiry register and BCD split stay in the top level.

Test Plan (TICK_DIV = 4):
1. Reset, then load with state_in = 00 → remaining = 15 one cycle after the load edge; first decrement 4 edges later; timer_zero high for exactly one cycle following the 60th edge after load; remaining = 0 afterwards and stays 0.
2. Load YELLOW (01) → remaining = 3, bcd = 0/3; timer_zero pulses after 12 edges. Immediately reload RED (10) → remaining = 10, bcd_tens = 1, bcd_ones = 0; expiry after 40 edges.
3. Load GREEN, drop enable for 7 cycles after the 2nd tick → remaining frozen at 13; expiry delayed by exactly 7 cycles (67 edges total).
4. Assert timer_load with state_in = 00 on the exact edge remaining goes 1→0 → no timer_zero pulse; remaining = 15; the count restarts.
5. Load with state_in = 11 → load_err pulses once; remaining = 10 (RED_TIME).
6. Assert rst at remaining = 5 → all outputs 0 the next cycle; no timer_zero for ≥ 100 cycles without a load.
